ip_codma_mem_responder: RTL and testbench
=========================================

# ip_codma_mem_responder

Slave-side responder for the CODMA memory bus. It accepts read and write burst requests from the CODMA read and write machines, arbitrates between them, and issues a grant or an error. It then moves 64-bit data beats to or from an internal word-addressed memory. It sits at the far end of the bus as the bench and system-level memory model, and as a synthesizable scratch memory.

## Interface

Parameters:
- DEPTH, 1024: memory size in 64-bit words; must be a power of two.
- GRANT_LATENCY, 2: wait cycles between request acceptance and grant/error (0–15).

Ports:
- clk_i  in  1  single clock; all logic on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- read_valid_i  in  1  read request; held by master until grant_o or error_o.
- write_valid_i  in  1  write request; held by master until grant_o or error_o.
- addr_i  in  32  byte address of burst start.
- size_i  in  4  burst size code (3 = 1 beat, 8 = 2 beats, 9 = 4 beats).
- write_data_i  in  64  write beat data, sampled on data-phase cycles.
- grant_o  out  1  one-cycle grant pulse.
- error_o  out  1  one-cycle error pulse, replaces grant.
- read_data_o  out  64  read beat data, valid on data-phase cycles.

## Operation

- States: RSP_IDLE, RSP_WAIT, RSP_GRANT, RSP_READ, RSP_WRITE, RSP_ERROR.
- RSP_IDLE:
  - Samples the request.
  - If read_valid_i or write_valid_i is high, latches addr_i, size_i and direction, then goes to RSP_WAIT.
  - If both are high in the same cycle, write wins; the read stays pending.
- RSP_WAIT:
  - Counts GRANT_LATENCY cycles.
  - If the latched request line drops before the count expires, returns to RSP_IDLE without any pulse (abort).
  - On expiry, checks the request:
    - Illegal size_i, addr_i[2:0] != 0, or beat address + beats > DEPTH goes to RSP_ERROR.
    - Otherwise goes to RSP_GRANT.
- RSP_GRANT:
  - grant_o = 1 for exactly one cycle.
  - The RAM read of beat 0 is issued in this cycle.
  - Next state is RSP_READ or RSP_WRITE.
- RSP_READ / RSP_WRITE:
  - One beat per cycle for N beats; beat k uses word (addr_i >> 3) + k.
  - Beat counter is 2 bits and counts 0..N-1; after the last beat the block returns to RSP_IDLE.
  - A write stores write_data_i on each beat.
  - A read drives read_data_o each beat and 0 outside beats.
- RSP_ERROR:
  - error_o = 1 for one cycle, then RSP_IDLE.
  - No memory access occurs.
- No address wrap: an out-of-range burst is rejected whole, never truncated.
- Unreachable state encodings go to RSP_IDLE.

## Timing

- Reset values: grant_o = 0, error_o = 0, read_data_o = 0, state RSP_IDLE, counters 0.
- Memory contents are not reset.
- Request sampled high in RSP_IDLE at cycle T: grant_o or error_o is high at cycle T+1+GRANT_LATENCY.
- Data beats occupy cycles G+1 .. G+N, where G is the grant cycle.
- Read data comes from a 1-cycle synchronous RAM, with the address issued one cycle ahead of each beat.
- Back-to-back bursts: the next request is sampled at the earliest in the cycle after the last beat.
- A reset mid-burst returns the block to RSP_IDLE immediately. Beats already written persist; the rest are dropped.
- A write followed immediately by a read of the same word returns the new data, because the write completes before the read is issued.

## Structure

- In ip_codma_pkg:
  - rsp_state_t enum.
  - Constants SIZE_1BEAT = 4'd3, SIZE_2BEAT = 4'd8, SIZE_4BEAT = 4'd9.
  - Function size_to_beats() returning 0 for illegal codes.
- Sub-module ip_codma_mem_array:
  - Single-port synchronous RAM, DEPTH×64.
  - Write enable and 1-cycle read latency.

## Test plan

- Write then read, size 9, addr 0x40, data 0x11..0x44, GRANT_LATENCY 2:
  - Write grant at T+3, four write beats.
  - Read returns 0x11, 0x22, 0x33, 0x44 on G+1..G+4.
- Size 3 write at addr 0x8 with data 0xDEAD_BEEF_0000_0001, then a size 3 read:
  - One beat; read_data_o = 0xDEAD_BEEF_0000_0001 at G+1.
- Error cases:
  - addr 0x4 → error_o pulse at T+3, no grant, memory unchanged.
  - size_i = 5 → error_o pulse.
  - size 9 at word DEPTH-2 → error_o pulse.
- Simultaneous read_valid_i and write_valid_i:
  - Write is granted first.
  - Read is granted after the write burst completes, and returns the new data.
- Request dropped during RSP_WAIT → no grant_o or error_o; block returns to RSP_IDLE and the next request is served normally.
- reset_i asserted on beat 2 of a size 9 write:
  - Outputs are 0 on the next cycle.
  - Words 0–1 are written; words 2–3 keep their old values.

Source files
------------

// File: rtl/ip_codma_pkg.sv
// Shared types and helpers for the CODMA memory responder.
//   rsp_state_t   : responder FSM state encoding
//   rsp_req_t     : latched burst request (address, size code, direction)
//   SIZE_*        : legal burst size codes
//   size_to_beats : size code to beat count, 0 for illegal codes
package ip_codma_pkg;

    typedef enum logic [2:0] {
        RSP_IDLE  = 3'd0,
        RSP_WAIT  = 3'd1,
        RSP_GRANT = 3'd2,
        RSP_READ  = 3'd3,
        RSP_WRITE = 3'd4,
        RSP_ERROR = 3'd5
    } rsp_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  size;
        logic        is_write;
    } rsp_req_t;

    localparam logic [3:0] SIZE_1BEAT = 4'd3;
    localparam logic [3:0] SIZE_2BEAT = 4'd8;
    localparam logic [3:0] SIZE_4BEAT = 4'd9;

    // Beat count for a size code; 0 marks an illegal code.
    function automatic logic [2:0] size_to_beats(input logic [3:0] size);
        logic [2:0] beats;
        beats = 3'd0;
        case (size)
            SIZE_1BEAT: beats = 3'd1;
            SIZE_2BEAT: beats = 3'd2;
            SIZE_4BEAT: beats = 3'd4;
            default:    beats = 3'd0;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/ip_codma_mem_array.sv
// Single-port synchronous RAM, DEPTH x 64, one-cycle read latency.
//   clk_i    : clock
//   reset_i  : synchronous active-high reset (clears the read register only)
//   we_i     : write enable, stores wdata_i at addr_i
//   re_i     : read enable; rdata_o holds mem[addr_i] next cycle, 0 when not reading
//   addr_i   : word address
//   wdata_i  : write data
//   rdata_o  : registered read data
module ip_codma_mem_array #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [63:0]   wdata_i,
    output logic [63:0]   rdata_o
);

    logic [63:0] mem [DEPTH];

    // Storage: contents survive reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    // Read register doubles as the bus data output, so it idles at zero.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rdata_o <= 64'd0;
        end else if (re_i) begin
            rdata_o <= mem[addr_i];
        end else begin
            rdata_o <= 64'd0;
        end
    end

endmodule

// File: rtl/ip_codma_mem_responder.sv
// Slave-side responder for the CODMA memory bus: arbitrates read/write burst
// requests, answers with a grant or error pulse after GRANT_LATENCY wait
// cycles, then moves 64-bit beats to/from an internal word-addressed RAM.
//   clk_i         : clock
//   reset_i       : synchronous active-high reset
//   read_valid_i  : read request, held until grant_o/error_o
//   write_valid_i : write request, held until grant_o/error_o (wins ties)
//   addr_i        : burst start byte address
//   size_i        : burst size code (3/8/9 = 1/2/4 beats)
//   write_data_i  : write beat data, sampled on data-phase cycles
//   grant_o       : one-cycle grant pulse
//   error_o       : one-cycle error pulse in place of grant
//   read_data_o   : read beat data on data-phase cycles, 0 otherwise
module ip_codma_mem_responder
    import ip_codma_pkg::*;
#(
    parameter int unsigned DEPTH         = 1024,
    parameter int unsigned GRANT_LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        read_valid_i,
    input  logic        write_valid_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  size_i,
    input  logic [63:0] write_data_i,
    output logic        grant_o,
    output logic        error_o,
    output logic [63:0] read_data_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rsp_state_t  state_q, state_d;
    rsp_req_t    req_q, req_d;
    rsp_req_t    req_in_c;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [1:0]  beat_q, beat_d;
    logic        req_line_c;
    logic [1:0]  last_beat_c;
    logic [AW-1:0] base_word_c;
    logic        ram_we_c;
    logic        ram_re_c;
    logic [AW-1:0] ram_addr_c;

    // A burst is legal when the size code is known, the address is word
    // aligned and every beat lands inside the array (no wrap, no truncation).
    function automatic logic req_ok(input rsp_req_t r);
        logic [2:0]  beats;
        logic [32:0] end_word;
        beats    = size_to_beats(r.size);
        end_word = 33'(r.addr[31:3]) + 33'(beats);
        return (beats != 3'd0) && (r.addr[2:0] == 3'b000) && (end_word <= 33'(DEPTH));
    endfunction

    always_comb begin
        req_in_c.addr     = addr_i;
        req_in_c.size     = size_i;
        req_in_c.is_write = write_valid_i;
    end

    // Abort detection follows only the line that won arbitration.
    assign req_line_c  = req_q.is_write ? write_valid_i : read_valid_i;
    assign last_beat_c = 2'(size_to_beats(req_q.size) - 3'd1);
    assign base_word_c = req_q.addr[AW+2:3];

    // Next-state, RAM control and latched request.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        wait_cnt_d = wait_cnt_q;
        beat_d     = beat_q;
        ram_we_c   = 1'b0;
        ram_re_c   = 1'b0;
        ram_addr_c = base_word_c + AW'(beat_q);

        case (state_q)
            RSP_IDLE: begin
                if (write_valid_i || read_valid_i) begin
                    req_d      = req_in_c;
                    wait_cnt_d = 4'd0;
                    beat_d     = 2'd0;
                    if (GRANT_LATENCY == 0) begin
                        state_d = req_ok(req_in_c) ? RSP_GRANT : RSP_ERROR;
                    end else begin
                        state_d = RSP_WAIT;
                    end
                end
            end

            RSP_WAIT: begin
                if (!req_line_c) begin
                    state_d = RSP_IDLE;
                end else if (wait_cnt_q == 4'(GRANT_LATENCY - 1)) begin
                    state_d = req_ok(req_q) ? RSP_GRANT : RSP_ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end

            // Beat 0 read is issued here so its data lands on the first beat.
            RSP_GRANT: begin
                ram_re_c   = !req_q.is_write;
                ram_addr_c = base_word_c;
                beat_d     = 2'd0;
                state_d    = req_q.is_write ? RSP_WRITE : RSP_READ;
            end

            // Prefetch the next word one cycle ahead of its beat.
            RSP_READ: begin
                if (beat_q == last_beat_c) begin
                    beat_d  = 2'd0;
                    state_d = RSP_IDLE;
                end else begin
                    ram_re_c   = 1'b1;
                    ram_addr_c = base_word_c + AW'(beat_q) + AW'(1);
                    beat_d     = beat_q + 2'd1;
                end
            end

            // A reset landing on a beat suppresses that beat's write.
            RSP_WRITE: begin
                ram_we_c   = !reset_i;
                ram_addr_c = base_word_c + AW'(beat_q);
                if (beat_q == last_beat_c) begin
                    beat_d  = 2'd0;
                    state_d = RSP_IDLE;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end

            RSP_ERROR: begin
                state_d = RSP_IDLE;
            end

            default: begin
                state_d = RSP_IDLE;
            end
        endcase
    end

    // State register; grant/error pulses are registered from the next state.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= RSP_IDLE;
            req_q      <= '0;
            wait_cnt_q <= 4'd0;
            beat_q     <= 2'd0;
            grant_o    <= 1'b0;
            error_o    <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            wait_cnt_q <= wait_cnt_d;
            beat_q     <= beat_d;
            grant_o    <= (state_d == RSP_GRANT);
            error_o    <= (state_d == RSP_ERROR);
        end
    end

    ip_codma_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem_array (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .we_i    (ram_we_c),
        .re_i    (ram_re_c),
        .addr_i  (ram_addr_c),
        .wdata_i (write_data_i),
        .rdata_o (read_data_o)
    );

endmodule

// File: tb/tb_ip_codma_mem_responder.sv
// Self-checking bench for ip_codma_mem_responder: tasks per scenario, with a
// shadow memory model feeding an expected-read-beat queue.
module tb_ip_codma_mem_responder;
    import ip_codma_pkg::*;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned GL    = 2;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        read_valid_i = 1'b0;
    logic        write_valid_i = 1'b0;
    logic [31:0] addr_i = 32'd0;
    logic [3:0]  size_i = 4'd0;
    logic [63:0] write_data_i = 64'd0;
    logic        grant_o;
    logic        error_o;
    logic [63:0] read_data_o;

    int cyc = 0;
    int tests_run = 0;
    int tests_failed = 0;

    logic [63:0] mem_model [int];
    logic [63:0] wdata_q [$];
    logic [63:0] exp_q [$];
    logic [63:0] got_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ip_codma_mem_responder #(
        .DEPTH         (DEPTH),
        .GRANT_LATENCY (GL)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .read_valid_i  (read_valid_i),
        .write_valid_i (write_valid_i),
        .addr_i        (addr_i),
        .size_i        (size_i),
        .write_data_i  (write_data_i),
        .grant_o       (grant_o),
        .error_o       (error_o),
        .read_data_o   (read_data_o)
    );

    // Master driver: request, wait (bounded) for grant/error, run data beats.
    task automatic run_req(input logic wr, input logic [31:0] addr, input logic [3:0] size,
                           input int n, output int req_cyc, output int rsp_cyc,
                           output logic got_grant, output logic got_error);
        @(posedge clk); #1;
        req_cyc   = cyc;
        rsp_cyc   = -1;
        got_grant = 1'b0;
        got_error = 1'b0;
        addr_i    = addr;
        size_i    = size;
        if (wr) write_valid_i = 1'b1;
        else    read_valid_i  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (grant_o || error_o) begin
                rsp_cyc   = cyc;
                got_grant = grant_o;
                got_error = error_o;
                break;
            end
        end
        write_valid_i = 1'b0;
        read_valid_i  = 1'b0;
        if (got_grant) begin
            for (int k = 0; k < n; k++) begin
                @(posedge clk); #1;
                write_data_i = (wr && wdata_q.size() > 0) ? wdata_q.pop_front() : 64'd0;
                @(negedge clk);
                if (!wr) got_q.push_back(read_data_o);
            end
        end
        wdata_q.delete();
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (grant_o !== 1'b0) begin tests_failed++; $display("FAIL reset_grant: got %b want 0", grant_o); end
        tests_run++;
        if (error_o !== 1'b0) begin tests_failed++; $display("FAIL reset_error: got %b want 0", error_o); end
        tests_run++;
        if (read_data_o !== 64'd0) begin tests_failed++; $display("FAIL reset_rdata: got %h want 0", read_data_o); end
        @(posedge clk); #1;
        reset_i = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (grant_o !== 1'b0 || error_o !== 1'b0) begin
            tests_failed++; $display("FAIL idle_quiet: got grant %b error %b want 0 0", grant_o, error_o);
        end
    endtask

    task automatic test_burst4();
        int rq, rs; logic gg, ge;
        logic [63:0] d [4];
        d[0] = 64'h11; d[1] = 64'h22; d[2] = 64'h33; d[3] = 64'h44;
        for (int k = 0; k < 4; k++) begin wdata_q.push_back(d[k]); mem_model[8 + k] = d[k]; end
        run_req(1'b1, 32'h40, SIZE_4BEAT, 4, rq, rs, gg, ge);
        tests_run++;
        if (!gg || ge || rs !== rq + 1 + int'(GL)) begin
            tests_failed++; $display("FAIL burst4_wr_grant: got grant %b error %b cycle %0d want 1 0 %0d", gg, ge, rs, rq + 1 + int'(GL));
        end
        for (int k = 0; k < 4; k++) exp_q.push_back(mem_model[8 + k]);
        run_req(1'b0, 32'h40, SIZE_4BEAT, 4, rq, rs, gg, ge);
        tests_run++;
        if (!gg || rs !== rq + 1 + int'(GL)) begin
            tests_failed++; $display("FAIL burst4_rd_grant: got grant %b cycle %0d want 1 %0d", gg, rs, rq + 1 + int'(GL));
        end
        @(negedge clk);
        tests_run++;
        if (read_data_o !== 64'd0) begin tests_failed++; $display("FAIL burst4_rd_idle: got %h want 0", read_data_o); end
        while (exp_q.size() > 0) begin
            logic [63:0] e, g;
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 64'hx;
            tests_run++;
            if (g !== e) begin tests_failed++; $display("FAIL burst4_beat: got %h want %h", g, e); end
        end
        got_q.delete();
    endtask

    task automatic test_single();
        int rq, rs; logic gg, ge;
        wdata_q.push_back(64'hDEAD_BEEF_0000_0001);
        mem_model[1] = 64'hDEAD_BEEF_0000_0001;
        run_req(1'b1, 32'h8, SIZE_1BEAT, 1, rq, rs, gg, ge);
        tests_run++;
        if (!gg || ge) begin tests_failed++; $display("FAIL single_wr_grant: got grant %b error %b want 1 0", gg, ge); end
        exp_q.push_back(mem_model[1]);
        run_req(1'b0, 32'h8, SIZE_1BEAT, 1, rq, rs, gg, ge);
        tests_run++;
        if (!gg || rs !== rq + 1 + int'(GL)) begin
            tests_failed++; $display("FAIL single_rd_grant: got grant %b cycle %0d want 1 %0d", gg, rs, rq + 1 + int'(GL));
        end
        while (exp_q.size() > 0) begin
            logic [63:0] e, g;
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 64'hx;
            tests_run++;
            if (g !== e) begin tests_failed++; $display("FAIL single_beat: got %h want %h", g, e); end
        end
        got_q.delete();
    endtask

    task automatic test_errors();
        int rq, rs; logic gg, ge;
        logic [31:0] a_bad, a_edge;
        a_bad  = 32'((DEPTH - 2) * 8);
        a_edge = 32'((DEPTH - 4) * 8);
        wdata_q.push_back(64'h0A0A_0A0A_0A0A_0A0A);
        mem_model[0] = 64'h0A0A_0A0A_0A0A_0A0A;
        run_req(1'b1, 32'h0, SIZE_1BEAT, 1, rq, rs, gg, ge);
        // Misaligned write must not disturb word 0.
        wdata_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        run_req(1'b1, 32'h4, SIZE_1BEAT, 1, rq, rs, gg, ge);
        tests_run++;
        if (gg || !ge || rs !== rq + 1 + int'(GL)) begin
            tests_failed++; $display("FAIL err_misaligned: got grant %b error %b cycle %0d want 0 1 %0d", gg, ge, rs, rq + 1 + int'(GL));
        end
        run_req(1'b0, 32'h40, 4'd5, 1, rq, rs, gg, ge);
        tests_run++;
        if (gg || !ge) begin tests_failed++; $display("FAIL err_size5: got grant %b error %b want 0 1", gg, ge); end
        run_req(1'b1, a_bad, SIZE_4BEAT, 4, rq, rs, gg, ge);
        tests_run++;
        if (gg || !ge) begin tests_failed++; $display("FAIL err_overrun: got grant %b error %b want 0 1", gg, ge); end
        // Last legal 4-beat burst ends exactly at the top word.
        for (int k = 0; k < 4; k++) begin
            wdata_q.push_back(64'hE0 + 64'(k));
            mem_model[int'(DEPTH) - 4 + k] = 64'hE0 + 64'(k);
        end
        run_req(1'b1, a_edge, SIZE_4BEAT, 4, rq, rs, gg, ge);
        tests_run++;
        if (!gg || ge) begin tests_failed++; $display("FAIL top_edge_grant: got grant %b error %b want 1 0", gg, ge); end
        exp_q.push_back(mem_model[0]);
        run_req(1'b0, 32'h0, SIZE_1BEAT, 1, rq, rs, gg, ge);
        for (int k = 0; k < 4; k++) exp_q.push_back(mem_model[int'(DEPTH) - 4 + k]);
        run_req(1'b0, a_edge, SIZE_4BEAT, 4, rq, rs, gg, ge);
        while (exp_q.size() > 0) begin
            logic [63:0] e, g;
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 64'hx;
            tests_run++;
            if (g !== e) begin tests_failed++; $display("FAIL errors_readback: got %h want %h", g, e); end
        end
        got_q.delete();
    endtask

    task automatic test_simultaneous();
        int t, g1, g2; logic gw;
        logic [63:0] d [2];
        d[0] = 64'h5151_0000_0000_0001; d[1] = 64'h5151_0000_0000_0002;
        g1 = -1; g2 = -1; gw = 1'b0;
        @(posedge clk); #1;
        t = cyc;
        addr_i = 32'h100; size_i = SIZE_2BEAT;
        write_valid_i = 1'b1; read_valid_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (grant_o || error_o) begin g1 = cyc; gw = grant_o; break; end
        end
        write_valid_i = 1'b0;
        tests_run++;
        if (!gw || g1 !== t + 1 + int'(GL)) begin
            tests_failed++; $display("FAIL simul_write_first: got grant %b cycle %0d want 1 %0d", gw, g1, t + 1 + int'(GL));
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            write_data_i = d[k];
            mem_model[32 + k] = d[k];
            @(negedge clk);
        end
        exp_q.push_back(mem_model[32]);
        exp_q.push_back(mem_model[33]);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (grant_o || error_o) begin g2 = cyc; break; end
        end
        read_valid_i = 1'b0;
        tests_run++;
        if (g2 !== g1 + 4 + int'(GL)) begin
            tests_failed++; $display("FAIL simul_read_grant: got cycle %0d want %0d", g2, g1 + 4 + int'(GL));
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            got_q.push_back(read_data_o);
        end
        while (exp_q.size() > 0) begin
            logic [63:0] e, g;
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 64'hx;
            tests_run++;
            if (g !== e) begin tests_failed++; $display("FAIL simul_beat: got %h want %h", g, e); end
        end
        got_q.delete();
    endtask

    task automatic test_abort();
        int rq, rs, pulses; logic gg, ge;
        pulses = 0;
        @(posedge clk); #1;
        addr_i = 32'h40; size_i = SIZE_1BEAT; read_valid_i = 1'b1;
        @(posedge clk); #1;
        read_valid_i = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (grant_o || error_o) pulses++;
        end
        tests_run++;
        if (pulses !== 0) begin tests_failed++; $display("FAIL abort_pulses: got %0d want 0", pulses); end
        exp_q.push_back(mem_model[8]);
        run_req(1'b0, 32'h40, SIZE_1BEAT, 1, rq, rs, gg, ge);
        tests_run++;
        if (!gg || rs !== rq + 1 + int'(GL)) begin
            tests_failed++; $display("FAIL abort_next_grant: got grant %b cycle %0d want 1 %0d", gg, rs, rq + 1 + int'(GL));
        end
        while (exp_q.size() > 0) begin
            logic [63:0] e, g;
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 64'hx;
            tests_run++;
            if (g !== e) begin tests_failed++; $display("FAIL abort_next_beat: got %h want %h", g, e); end
        end
        got_q.delete();
    endtask

    task automatic test_reset_mid_burst();
        int rq, rs; logic gg, ge, seen;
        logic [63:0] nd [4];
        for (int k = 0; k < 4; k++) begin
            wdata_q.push_back(64'hA0 + 64'(k));
            mem_model[64 + k] = 64'hA0 + 64'(k);
            nd[k] = 64'hB0 + 64'(k);
        end
        run_req(1'b1, 32'h200, SIZE_4BEAT, 4, rq, rs, gg, ge);
        seen = 1'b0;
        @(posedge clk); #1;
        addr_i = 32'h200; size_i = SIZE_4BEAT; write_valid_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (grant_o) begin seen = 1'b1; break; end
        end
        write_valid_i = 1'b0;
        tests_run++;
        if (!seen) begin tests_failed++; $display("FAIL rstmid_grant: got none want grant"); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            write_data_i = nd[k];
            if (k == 2) reset_i = 1'b1;
            @(negedge clk);
        end
        mem_model[64] = nd[0];
        mem_model[65] = nd[1];
        @(negedge clk);
        tests_run++;
        if (grant_o !== 1'b0 || error_o !== 1'b0 || read_data_o !== 64'd0) begin
            tests_failed++; $display("FAIL rstmid_outputs: got grant %b error %b rdata %h want 0 0 0", grant_o, error_o, read_data_o);
        end
        @(posedge clk); #1;
        reset_i = 1'b0;
        for (int k = 0; k < 4; k++) exp_q.push_back(mem_model[64 + k]);
        run_req(1'b0, 32'h200, SIZE_4BEAT, 4, rq, rs, gg, ge);
        tests_run++;
        if (!gg) begin tests_failed++; $display("FAIL rstmid_rd_grant: got %b want 1", gg); end
        while (exp_q.size() > 0) begin
            logic [63:0] e, g;
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 64'hx;
            tests_run++;
            if (g !== e) begin tests_failed++; $display("FAIL rstmid_beat: got %h want %h", g, e); end
        end
        got_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_burst4();
        test_single();
        test_errors();
        test_simultaneous();
        test_abort();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
